// File: rtl/t05_spi_arbiter.sv
// Round-robin arbiter that shares one t05_SPI engine between two requesters.
// All outputs are registered. Each pulse appears one cycle after the state that produces it.
module t05_spi_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 4095,
  parameter int CNT_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  output logic [1:0]          req_ready,
  output logic [1:0]          req_done,
  output logic [1:0]          req_timeout,
  output logic                busy,
  output logic                grant_id,
  output logic                spi_read_en,
  output logic                spi_write_en,
  output logic                spi_read_stop,
  output logic [ADDR_W-1:0]   spi_read_addr,
  output logic [ADDR_W-1:0]   spi_write_addr,
  input  logic                spi_finish
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STOP, ABORT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              op_write;
  logic              last_grant;
  logic              win;
  logic              accept;
  logic              cnt_hit;
  logic [ADDR_W-1:0] win_addr;

  logic [1:0] ready_nxt, done_nxt, timeout_nxt;
  logic       read_en_nxt, write_en_nxt, read_stop_nxt, busy_nxt;

  assign accept   = (state == IDLE) && (|req_valid);
  // Contention goes to the side that did not win last time
  assign win      = (&req_valid) ? ~last_grant : req_valid[1];
  assign win_addr = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign cnt_hit  = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      op_write       <= 1'b0;
      last_grant     <= 1'b1;
      grant_id       <= 1'b0;
      spi_read_addr  <= '0;
      spi_write_addr <= '0;
      req_ready      <= 2'b00;
      req_done       <= 2'b00;
      req_timeout    <= 2'b00;
      busy           <= 1'b0;
      spi_read_en    <= 1'b0;
      spi_write_en   <= 1'b0;
      spi_read_stop  <= 1'b0;
    end else begin
      state         <= state_nxt;
      req_ready     <= ready_nxt;
      req_done      <= done_nxt;
      req_timeout   <= timeout_nxt;
      busy          <= busy_nxt;
      spi_read_en   <= read_en_nxt;
      spi_write_en  <= write_en_nxt;
      spi_read_stop <= read_stop_nxt;
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + 1'b1;
      if (accept) begin
        grant_id   <= win;
        last_grant <= win;
        op_write   <= req_write[win];
        if (req_write[win])
          spi_write_addr <= win_addr;
        else
          spi_read_addr  <= win_addr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      // Finish takes priority over a coincident timeout
      WAIT: begin
        if (spi_finish)
          state_nxt = op_write ? DONE : STOP;
        else if (cnt_hit)
          state_nxt = ABORT;
      end
      STOP:  state_nxt = DONE;
      ABORT: state_nxt = IDLE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_nxt     = 2'b00;
    done_nxt      = 2'b00;
    timeout_nxt   = 2'b00;
    read_en_nxt   = 1'b0;
    write_en_nxt  = 1'b0;
    read_stop_nxt = 1'b0;
    if (accept)
      ready_nxt = win ? 2'b10 : 2'b01;
    if (state == ISSUE) begin
      write_en_nxt = op_write;
      read_en_nxt  = ~op_write;
    end
    if (state == STOP || state == ABORT)
      read_stop_nxt = 1'b1;
    if (state == DONE)
      done_nxt = {grant_id, ~grant_id};
    if (state == ABORT)
      timeout_nxt = {grant_id, ~grant_id};
    busy_nxt = accept | (busy & ~(|req_done) & ~(|req_timeout));
  end

endmodule
